// File: rtl/dcmac_0_axis_pkt_mon_dat_pack.sv
// Per-ID byte packer for the RX monitor path: merges partial words into dense 192-byte words,
// flushing each ID's residual as a short final word on end-of-packet.
module dcmac_0_axis_pkt_mon_dat_pack #(
  parameter int unsigned NUM_ID = 6,
  parameter int unsigned ID_W   = (NUM_ID == 1) ? 1 : $clog2(NUM_ID)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ena,
  output logic                  o_rdy,
  input  logic [ID_W-1:0]       i_id,
  input  logic [191:0][7:0]     i_dat,
  input  logic [7:0]            i_nbytes,
  input  logic                  i_eop,
  output logic                  o_vld,
  output logic [ID_W-1:0]       o_id,
  output logic [191:0][7:0]     o_dat,
  output logic [7:0]            o_nbytes,
  output logic                  o_eop,
  output logic                  o_err
);

  localparam int unsigned NCTX = 1 << ID_W;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q [NCTX];
  logic [190:0][7:0]   res_q [NCTX];
  logic [ID_W-1:0]     pend_id_q;

  logic                acc, bad_id, sat;
  logic [7:0]          nb, cur_cnt;
  logic [8:0]          tot;
  logic [191:0][7:0]   in_m;
  logic [190:0][7:0]   res_m;
  logic [382:0][7:0]   ext_in, ext_res, comb;

  logic                cnt_we, res_we;
  logic [ID_W-1:0]     ctx_id;
  logic [7:0]          cnt_d;
  logic [190:0][7:0]   res_d;

  logic                vld_d, eop_d, err_d;
  logic [ID_W-1:0]     id_d;
  logic [191:0][7:0]   dat_d;
  logic [7:0]          nb_d;

  assign o_rdy = (state_q == IDLE);

  always_comb begin
    acc     = i_ena & o_rdy;
    bad_id  = 32'(i_id) >= NUM_ID;
    sat     = i_nbytes > 8'd192;
    nb      = sat ? 8'd192 : i_nbytes;
    cur_cnt = cnt_q[i_id];
    tot     = {1'b0, cur_cnt} + {1'b0, nb};

    // Zero everything past the valid counts so comb is zero beyond tot and padding falls out free.
    for (int unsigned k = 0; k < 192; k++) in_m[k] = (k < 32'(nb)) ? i_dat[k] : 8'h00;
    for (int unsigned k = 0; k < 191; k++) res_m[k] = (k < 32'(cur_cnt)) ? res_q[i_id][k] : 8'h00;
    ext_in          = '0;
    ext_in[191:0]   = in_m;
    ext_res         = '0;
    ext_res[190:0]  = res_m;
    comb            = (ext_in << {cur_cnt, 3'b000}) | ext_res;
  end

  always_comb begin
    state_d = state_q;
    vld_d   = 1'b0;
    eop_d   = 1'b0;
    err_d   = 1'b0;
    id_d    = '0;
    dat_d   = '0;
    nb_d    = '0;
    cnt_we  = 1'b0;
    res_we  = 1'b0;
    ctx_id  = i_id;
    cnt_d   = cur_cnt;
    res_d   = (tot >= 9'd192) ? comb[382:192] : comb[190:0];

    case (state_q)
      IDLE: begin
        if (acc) begin
          err_d = bad_id | sat;
          if (!bad_id) begin
            cnt_we = 1'b1;
            res_we = 1'b1;
            id_d   = i_id;
            if (i_eop) begin
              if (tot > 9'd192) begin
                // Overflowing eop keeps the tail in res/cnt; the FLUSH cycle emits and clears it.
                vld_d   = 1'b1;
                dat_d   = comb[191:0];
                nb_d    = 8'd192;
                cnt_d   = 8'(tot - 9'd192);
                state_d = FLUSH;
              end else begin
                cnt_d = '0;
                if (tot != 9'd0) begin
                  vld_d = 1'b1;
                  eop_d = 1'b1;
                  dat_d = comb[191:0];
                  nb_d  = tot[7:0];
                end
              end
            end else if (tot >= 9'd192) begin
              vld_d = 1'b1;
              dat_d = comb[191:0];
              nb_d  = 8'd192;
              cnt_d = 8'(tot - 9'd192);
            end else begin
              cnt_d = tot[7:0];
            end
          end
        end
      end
      FLUSH: begin
        vld_d   = 1'b1;
        eop_d   = 1'b1;
        id_d    = pend_id_q;
        dat_d   = {8'h00, res_q[pend_id_q]};
        nb_d    = cnt_q[pend_id_q];
        cnt_we  = 1'b1;
        ctx_id  = pend_id_q;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '{default: '0};
      pend_id_q <= '0;
      o_vld     <= 1'b0;
      o_eop     <= 1'b0;
      o_err     <= 1'b0;
      o_id      <= '0;
      o_dat     <= '0;
      o_nbytes  <= '0;
    end else begin
      state_q  <= state_d;
      if (cnt_we) cnt_q[ctx_id] <= cnt_d;
      if (state_d == FLUSH) pend_id_q <= i_id;
      o_vld    <= vld_d;
      o_eop    <= eop_d;
      o_err    <= err_d;
      o_id     <= id_d;
      o_dat    <= dat_d;
      o_nbytes <= nb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (res_we) res_q[i_id] <= res_d;
  end

endmodule

// File: tb/tb_dcmac_0_axis_pkt_mon_dat_pack.sv
// Bench for the RX byte packer: per-ID byte queues model the expected word stream cycle by cycle.
module tb_dcmac_0_axis_pkt_mon_dat_pack;

  localparam int unsigned NUM_ID = 6;
  localparam int unsigned ID_W   = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                i_ena;
  logic                o_rdy;
  logic [ID_W-1:0]     i_id;
  logic [191:0][7:0]   i_dat;
  logic [7:0]          i_nbytes;
  logic                i_eop;
  logic                o_vld;
  logic [ID_W-1:0]     o_id;
  logic [191:0][7:0]   o_dat;
  logic [7:0]          o_nbytes;
  logic                o_eop;
  logic                o_err;

  dcmac_0_axis_pkt_mon_dat_pack #(.NUM_ID(NUM_ID)) dut (
    .clk(clk), .rst(rst), .i_ena(i_ena), .o_rdy(o_rdy), .i_id(i_id), .i_dat(i_dat),
    .i_nbytes(i_nbytes), .i_eop(i_eop), .o_vld(o_vld), .o_id(o_id), .o_dat(o_dat),
    .o_nbytes(o_nbytes), .o_eop(o_eop), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: pending bytes per ID, plus a queued flush word.
  logic [7:0]          mq [0:7][$];
  bit                  fl_v = 1'b0;
  int                  fl_id, fl_nb;
  logic [191:0][7:0]   fl_dat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cycle();
    bit                e_vld = 1'b0, e_err = 1'b0, e_eop = 1'b0;
    int                e_id = 0, e_nb = 0, n, sz;
    logic [191:0][7:0] e_dat = '0;
    if (rst) begin
      for (int i = 0; i < 8; i++) mq[i].delete();
      fl_v = 1'b0;
    end else if (fl_v) begin
      e_vld = 1'b1; e_eop = 1'b1; e_id = fl_id; e_nb = fl_nb; e_dat = fl_dat;
      fl_v = 1'b0;
    end else if (i_ena) begin
      if (int'(i_id) >= int'(NUM_ID)) begin
        e_err = 1'b1;
      end else begin
        e_err = (i_nbytes > 8'd192);
        n     = e_err ? 192 : int'(i_nbytes);
        e_id  = int'(i_id);
        for (int k = 0; k < n; k++) mq[e_id].push_back(i_dat[k]);
        sz = mq[e_id].size();
        if (sz >= 192 || (i_eop && sz > 0)) begin
          e_vld = 1'b1;
          e_nb  = (sz >= 192) ? 192 : sz;
          e_eop = i_eop && (sz <= 192);
          for (int k = 0; k < e_nb; k++) e_dat[k] = mq[e_id].pop_front();
          if (i_eop && sz > 192) begin
            fl_v   = 1'b1;
            fl_id  = e_id;
            fl_nb  = mq[e_id].size();
            fl_dat = '0;
            for (int k = 0; k < fl_nb; k++) fl_dat[k] = mq[e_id].pop_front();
          end
        end
      end
    end
    @(posedge clk);
    #1;
    chk("rdy", 64'(o_rdy), 64'(!fl_v));
    chk("vld", 64'(o_vld), 64'(e_vld));
    chk("err", 64'(o_err), 64'(e_err));
    if (rst || e_vld) begin
      chk("id", 64'(o_id), 64'(e_id));
      chk("nbytes", 64'(o_nbytes), 64'(e_nb));
      chk("eop", 64'(o_eop), 64'(e_eop));
      for (int l = 0; l < 24; l++)
        chk($sformatf("dat[%0d]", l), o_dat[l*8 +: 8], e_dat[l*8 +: 8]);
    end
  endtask

  task automatic beat(input int id, input int nb, input bit eop, input int base, input int step);
    i_ena    = 1'b1;
    i_id     = ID_W'(id);
    i_nbytes = 8'(nb);
    i_eop    = eop;
    for (int k = 0; k < 192; k++) i_dat[k] = 8'(base + step * k);
    cycle();
    i_ena = 1'b0;
    i_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    i_ena = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    int r, nb;
    rst = 1'b1; i_ena = 1'b0; i_id = '0; i_dat = '0; i_nbytes = '0; i_eop = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    idle(1);

    // same-ID accumulation, then flush the 8-byte remainder
    beat(0, 100, 0, 0, 1);
    beat(0, 100, 0, 100, 1);
    beat(0, 0, 1, 0, 0);

    // round-robin interleave with ID-tagged bytes
    for (int rd = 0; rd < 3; rd++)
      for (int id = 0; id < 3; id++) beat(id, 64, 0, id, 0);

    // overflowing eop; the beat offered during the flush cycle is ignored
    beat(0, 150, 0, 1, 1);
    beat(0, 100, 1, 7, 3);
    beat(2, 50, 0, 9, 1);
    idle(2);

    // short eop with zero padding
    beat(1, 10, 0, 5, 1);
    beat(1, 20, 1, 40, 1);

    // bad IDs and saturated byte count
    beat(6, 50, 0, 0, 1);
    beat(7, 10, 1, 0, 1);
    beat(0, 200, 0, 3, 1);

    // reset landing on the flush cycle
    beat(0, 150, 0, 0, 1);
    beat(0, 100, 1, 0, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    beat(0, 192, 0, 11, 1);
    idle(1);

    repeat (3000) begin
      rst   = ($urandom_range(0, 199) == 0);
      i_ena = ($urandom_range(0, 3) != 0);
      i_id  = ($urandom_range(0, 15) == 0) ? ID_W'(6 + $urandom_range(0, 1))
                                           : ID_W'($urandom_range(0, NUM_ID - 1));
      r = $urandom_range(0, 9);
      if (r < 6)       nb = $urandom_range(1, 192);
      else if (r < 8)  nb = $urandom_range(150, 192);
      else if (r == 8) nb = 0;
      else             nb = $urandom_range(193, 255);
      i_eop = ($urandom_range(0, 4) == 0);
      if (nb == 0) i_eop = 1'b1;
      i_nbytes = 8'(nb);
      for (int k = 0; k < 192; k++) i_dat[k] = 8'($urandom);
      cycle();
    end
    rst = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
